// File: rtl/dff_debounce_pkg.sv
// Shared definitions for the dff_debounce input-conditioning stage: FSM state encoding and defaults.
package dff_debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_WAIT_HI   = 2'b01,
    ST_STABLE_HI = 2'b10,
    ST_WAIT_LO   = 2'b11
  } state_e;

  localparam int DEFAULT_STABLE_CYCLES = 8;

endpackage

// File: rtl/dff_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to RESET_VAL.
module dff_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/dff_debounce.sv
// Synchronizes and debounces a raw level into a clean q/qb pair for the downstream dff.
// Optional DEBOUNCE_EDGE_EN adds registered rise/fall pulses aligned with the q change.
module dff_debounce
  import dff_debounce_pkg::*;
#(
  parameter int   CNT_W         = 4,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q,
  output logic qb,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam state_e           RST_STATE = RESET_VAL ? ST_STABLE_HI : ST_STABLE_LO;

  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("dff_debounce: STABLE_CYCLES out of range for CNT_W");
    end
  endgenerate

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  dff_sync2 #(.RESET_VAL(RESET_VAL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_raw),
    .q   (s2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  // cnt is cleared on every WAIT exit, so it never exceeds CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    case (state_q)
      ST_STABLE_LO: begin
        if (s2) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!s2) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HI;
          q_d     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE_HI: begin
        if (!s2) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (s2) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          q_d     = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign busy = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Registered from q_d so the pulse lands in the same cycle q first shows its new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule
